// File: rtl/uart_rx_8n1_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and default bit timing.
// The matching transmitter imports the same package.
package uart_rx_8n1_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Both flops reset to RST_VAL so an idle-high line reads idle out of reset.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: mid-bit sampling, break detection, and a one-entry
// holding register behind a valid/ready handshake.
module uart_rx_8n1
    import uart_rx_8n1_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    input  logic                      rx_ready,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    output logic                      rx_busy,
    output logic                      frame_err,
    output logic                      overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    uart_state_e               state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [2:0]                idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      rx_s;
    logic                      deliver;
    logic                      ferr_d;

    uart_sync2 #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (rx),
        .q  (rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter is cleared on every state change and on every sample.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_ONE;
        idx_d   = idx_q;
        shift_d = shift_q;
        deliver = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == MID_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        deliver = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            frame_err <= ferr_d;
            overrun   <= 1'b0;
            if (deliver) begin
                // A consumer taking the old byte this cycle frees the slot.
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift_q;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign rx_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed bench for uart_rx_8n1 at 16 clocks per bit.
module tb_uart_rx_8n1;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    int total = 0;
    int bad = 0;

    int         cyc = 0;
    int         valid_n = 0;
    int         ferr_n = 0;
    int         ovr_n = 0;
    int         take_n = 0;
    int         rise_cyc = 0;
    logic       prev_v = 1'b0;
    logic [7:0] last_taken = 8'h00;
    logic [7:0] prev_taken = 8'h00;

    uart_rx_8n1 #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_ready (rx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_busy  (rx_busy),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) valid_n++;
            if (rx_valid && !prev_v) rise_cyc = cyc;
            if (frame_err) ferr_n++;
            if (overrun) ovr_n++;
            if (rx_valid && rx_ready) begin
                prev_taken = last_taken;
                last_taken = rx_data;
                take_n++;
            end
            prev_v = rx_valid;
        end else begin
            prev_v = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    int v0, f0, o0, t0, t_start;

    initial begin
        tick(3);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_busy", rx_busy, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        rst = 1'b0;
        tick(5);
        check("idle_busy", rx_busy, 0);

        // 1: 8'hA5, ready high; 2 sync cycles + 8 + 144 + 1
        rx_ready = 1'b1;
        v0 = valid_n; f0 = ferr_n; o0 = ovr_n; t0 = take_n;
        t_start = cyc;
        send_frame(8'hA5, 1'b1);
        tick(10);
        check("t1_latency", rise_cyc - t_start, 155);
        check("t1_valid_cycles", valid_n - v0, 1);
        check("t1_takes", take_n - t0, 1);
        check("t1_data", last_taken, 8'hA5);
        check("t1_ferr", ferr_n - f0, 0);
        check("t1_ovr", ovr_n - o0, 0);
        check("t1_valid_now", rx_valid, 0);

        // 2: short glitch rejected at mid-start
        v0 = valid_n; f0 = ferr_n;
        rx = 1'b0;
        tick(4);
        check("t2_busy_hi", rx_busy, 1);
        rx = 1'b1;
        tick(20);
        check("t2_busy_lo", rx_busy, 0);
        check("t2_valid", valid_n - v0, 0);
        check("t2_ferr", ferr_n - f0, 0);

        // 3: bad stop bit then held-low line
        v0 = valid_n; f0 = ferr_n;
        send_frame(8'h3C, 1'b0);
        rx = 1'b0;
        tick(40);
        check("t3_ferr", ferr_n - f0, 1);
        check("t3_valid", valid_n - v0, 0);
        check("t3_busy_break", rx_busy, 1);
        rx = 1'b1;
        tick(6);
        check("t3_busy_idle", rx_busy, 0);
        check("t3_ferr_once", ferr_n - f0, 1);

        // 4: two bytes with no consumer
        rx_ready = 1'b0;
        o0 = ovr_n; t0 = take_n;
        send_frame(8'h01, 1'b1);
        send_frame(8'hFE, 1'b1);
        tick(10);
        check("t4_valid_held", rx_valid, 1);
        check("t4_data_held", rx_data, 8'h01);
        check("t4_ovr", ovr_n - o0, 1);
        check("t4_ovr_pulse", overrun, 0);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        check("t4_valid_clr", rx_valid, 0);
        check("t4_taken", last_taken, 8'h01);
        check("t4_takes", take_n - t0, 1);

        // 5: async reset in DATA bit 3 of 8'hFF
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        rx = 1'b1;
        tick(4);
        check("t5_busy_pre", rx_busy, 1);
        #2 rst = 1'b1;
        #1;
        check("t5_busy_rst", rx_busy, 0);
        check("t5_data_rst", rx_data, 0);
        check("t5_valid_rst", rx_valid, 0);
        tick(2);
        rst = 1'b0;
        tick(20);
        check("t5_busy_after", rx_busy, 0);
        rx_ready = 1'b1;
        v0 = valid_n; f0 = ferr_n; o0 = ovr_n; t0 = take_n;
        send_frame(8'h55, 1'b1);
        tick(10);
        check("t5_data", last_taken, 8'h55);
        check("t5_takes", take_n - t0, 1);
        check("t5_ferr", ferr_n - f0, 0);
        check("t5_ovr", ovr_n - o0, 0);

        // 6: 8'h00 then 8'hFF with no idle gap
        v0 = valid_n; f0 = ferr_n; t0 = take_n;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        tick(10);
        check("t6_pulses", valid_n - v0, 2);
        check("t6_takes", take_n - t0, 2);
        check("t6_first", prev_taken, 8'h00);
        check("t6_second", last_taken, 8'hFF);
        check("t6_ferr", ferr_n - f0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
